pru_cmd_sequencer: RTL

- Sits directly upstream of the pixel render unit, between the processor's memory-mapped bus and the render unit's shape/start/done interface.
- Captures shape parameters written by software and queues complete draw commands in a FIFO.
- Replays each command to the render unit with a start/done handshake, so software can post several shapes without polling.
- Forwards palette writes to the render unit's colour registers and exposes a status word.

---
 rtl/pru_cmd_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pru_cmd_sequencer.sv
// pru_cmd_sequencer
//   Bus-programmable command queue in front of the pixel render unit.
//   Software stages a position and a size, then a CMD write pushes a complete
//   draw command into a FIFO. A three-state sequencer replays each queued
//   command to the render unit with a start/done handshake. Palette writes
//   are forwarded as a one-cycle colour load. A status word is readable.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   bus_addr/wdata        processor address / write data
//   bus_we, bus_re        one-cycle write / read strobes
//   bus_rdata             registered read data (valid the cycle after bus_re)
//   pru_col .. pru_subtract  shape outputs, latched on each FIFO pop
//   pru_start             start request, high while a command is issued
//   pru_done, pru_busy    render unit handshake / status
//   color_load            one-cycle palette write pulse
//   pru_addr, pru_data    palette address / data, held until next palette write
//   irq_idle              one-cycle pulse when the queue drains
module pru_cmd_sequencer #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] BASE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic [9:0]  pru_col,
  output logic [8:0]  pru_row,
  output logic [9:0]  pru_width,
  output logic [8:0]  pru_height_radius,
  output logic [1:0]  pru_color,
  output logic [1:0]  pru_shape_select,
  output logic        pru_subtract,
  output logic        pru_start,
  input  logic        pru_done,
  input  logic        pru_busy,
  output logic        color_load,
  output logic [31:0] pru_addr,
  output logic [31:0] pru_data,
  output logic        irq_idle
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
    logic [9:0] width;
    logic [8:0] hr;
    logic [1:0] color;
    logic [1:0] shape;
    logic       sub;
  } cmd_t;

  // Address decode
  logic [31:0] off;
  logic        sel_pos, sel_size, sel_cmd, sel_pal, sel_status, sel_ctrl;

  assign off        = bus_addr - BASE;
  assign sel_pos    = (off == 32'h00);
  assign sel_size   = (off == 32'h04);
  assign sel_cmd    = (off == 32'h08);
  assign sel_status = (off == 32'h1C);
  assign sel_ctrl   = (off == 32'h20);
  // Word-aligned offsets 0x0C, 0x10, 0x14, 0x18
  assign sel_pal    = (off[31:5] == '0) && (off[1:0] == 2'b00) &&
                      (off[4:2] >= 3'd3) && (off[4:2] <= 3'd6);

  logic wr_pos, wr_size, wr_cmd, wr_pal, flush, clr_ovf;

  assign wr_pos  = bus_we && sel_pos;
  assign wr_size = bus_we && sel_size;
  assign wr_cmd  = bus_we && sel_cmd;
  assign wr_pal  = bus_we && sel_pal;
  assign flush   = bus_we && sel_ctrl && bus_wdata[1];
  assign clr_ovf = bus_we && sel_ctrl && bus_wdata[0];

  // Staging registers
  logic [9:0] stg_col;
  logic [8:0] stg_row;
  logic [9:0] stg_width;
  logic [8:0] stg_hr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_col   <= '0;
      stg_row   <= '0;
      stg_width <= '0;
      stg_hr    <= '0;
    end else begin
      if (wr_pos) begin
        stg_col <= bus_wdata[9:0];
        stg_row <= bus_wdata[24:16];
      end
      if (wr_size) begin
        stg_width <= bus_wdata[9:0];
        stg_hr    <= bus_wdata[24:16];
      end
    end
  end

  // Command FIFO
  state_t      state, state_nxt;
  cmd_t        mem [DEPTH];
  cmd_t        new_cmd, head;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        empty, full, pop, push, ovf_set, overflow;

  assign new_cmd = '{col: stg_col, row: stg_row, width: stg_width, hr: stg_hr,
                     color: bus_wdata[1:0], shape: bus_wdata[3:2],
                     sub: bus_wdata[4]};
  assign head    = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = (state == S_IDLE) && !empty && !pru_done;
  // A simultaneous pop frees the slot, so a push at full still succeeds.
  assign push    = wr_cmd && !flush && (!full || pop);
  assign ovf_set = wr_cmd && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= new_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // Flush discards everything unissued; an entry popped this cycle is
      // already latched onto the shape outputs.
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Sequencer FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pru_start = 1'b0;
    unique case (state)
      S_IDLE:    if (!empty && !pru_done) state_nxt = S_ISSUE;
      S_ISSUE: begin
        pru_start = 1'b1;
        if (pru_done) state_nxt = S_RELEASE;
      end
      S_RELEASE: if (!pru_done) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Shape outputs and drain interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pru_col           <= '0;
      pru_row           <= '0;
      pru_width         <= '0;
      pru_height_radius <= '0;
      pru_color         <= '0;
      pru_shape_select  <= '0;
      pru_subtract      <= 1'b0;
      irq_idle          <= 1'b0;
    end else begin
      if (pop) begin
        pru_col           <= head.col;
        pru_row           <= head.row;
        pru_width         <= head.width;
        pru_height_radius <= head.hr;
        pru_color         <= head.color;
        pru_shape_select  <= head.shape;
        pru_subtract      <= head.sub;
      end
      irq_idle <= (state == S_RELEASE) && !pru_done && empty && !push;
    end
  end

  // Palette forwarding and register read
  logic [31:0] status;

  assign status = {19'd0, pru_busy, (state != S_IDLE), overflow, full, empty,
                   8'(count)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_load <= 1'b0;
      pru_addr   <= '0;
      pru_data   <= '0;
      bus_rdata  <= '0;
    end else begin
      color_load <= wr_pal;
      if (wr_pal) begin
        pru_addr <= bus_addr;
        pru_data <= bus_wdata;
      end
      if (bus_re) bus_rdata <= sel_status ? status : 32'd0;
    end
  end

endmodule
